mem_req_sched: RTL and testbench
================================

Name: mem_req_sched

Overview:
- Request scheduler that sits directly upstream of the single-port memory block (mem_d).
- Accepts read/write requests from a host over a valid/ready handshake and buffers them in an in-order FIFO.
- Issues at most one request per cycle on the memory's rd_wr_valid/rd_wr_mem/mem_addr/wr_data interface.
- Captures returned read data and presents it to the host as a valid/ready response.

Parameters:
DATA_WIDTH, 32, width of write and read data
ADDR_WIDTH, 16, width of memory address
DEPTH, 8, request FIFO entries; power of 2, at least 2

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  host request valid
req_ready  out  1  scheduler can accept a request
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data; ignored for reads
resp_valid  out  1  read response valid
resp_ready  in  1  host accepts the response
resp_rdata  out  DATA_WIDTH  read data
mem_rd_wr_valid  out  1  issue strobe to memory
mem_rd_wr_mem  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  issued address
mem_wr_data  out  DATA_WIDTH  issued write data
mem_rd_data  in  DATA_WIDTH  memory read data, registered by memory, valid the cycle after a read issue
fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high. Reset polarity adaptation for the memory is done outside this block.
- Reset values: FIFO empty, fifo_count=0, req_ready=1, resp_valid=0, resp_rdata=0, rd_inflight=0, mem_rd_wr_valid=0.
- Reset mid-operation: queued requests and any in-flight read are discarded. No response is produced for them.
- Push:
  - Happens on req_valid && req_ready.
  - req_ready = !full. It does not account for a same-cycle pop.
- Pop/issue:
  - mem_* outputs are driven combinationally from the registered FIFO head, so there is no combinational path from req_* to mem_*.
  - mem_rd_wr_valid = issue, where issue = !empty && (head.wr || rd_ok).
  - rd_ok = !rd_inflight && (!resp_valid || resp_ready).
  - Writes issue even while a read is in flight.
  - In-order only: a blocked read at the head stalls the writes behind it.
  - No bypass: a request pushed in cycle T can issue no earlier than T+1.
- Read tracking:
  - A read issue sets rd_inflight at the clock edge.
  - In the following cycle the scheduler captures resp_rdata<=mem_rd_data, sets resp_valid<=1 and clears rd_inflight.
- Response:
  - resp_valid and resp_rdata hold stable until resp_ready.
  - If the host handshake and a new capture fall on the same edge, the capture wins and resp_valid stays 1.
  - At most one read is outstanding between issue and response.
- Latency: with an empty FIFO and the host ready, a read accepted in cycle T has resp_valid high in T+3. A write accepted in T appears on mem_* in T+1.
- Occupancy:
  - fifo_count updates every cycle: +1 on push only, -1 on pop only, unchanged on push+pop.
  - A simultaneous push and pop while full cannot occur, because req_ready=0 when full.
- Wrap-around: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full/empty derive from fifo_count.
- Ordering: a read followed by a write to the same address returns the old data, because memory samples on the issue edge.

Decomposition:
- Package mem_ctrl_pkg:
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - mem_req_t packed struct {wr, addr, wdata}.
  - Opcode constants OP_RD=0, OP_WR=1.
- One sub-module, mem_req_fifo: a synchronous FIFO of mem_req_t with push/pop/full/empty/count.
- The issue/response logic stays in mem_req_sched.

Test Plan:
- Reset then idle: req_ready=1, resp_valid=0, fifo_count=0, mem_rd_wr_valid=0 for 10 cycles.
- Write 0xDEADBEEF to addr 0x0010, then read 0x0010 with resp_ready=1 -> resp_rdata=0xDEADBEEF, resp_valid high exactly 3 cycles after the read handshake.
- Push 8 writes back-to-back with mem issue blocked by a preceding held read (resp_ready=0) -> fifo_count reaches 8 and req_ready=0. Releasing resp_ready drains the FIFO one request per cycle, in order.
- Two reads (addr 0x1, 0x2) with resp_ready=0 -> first response holds, second read is not issued (mem_rd_wr_valid=0). After resp_ready=1, the second read is issued and returns correctly.
- 20 alternating push/pop cycles across the pointer wrap (DEPTH=8) -> data order preserved, fifo_count steady, no loss.
- Assert rst while a read is in flight -> next cycle resp_valid=0, fifo_count=0, and no response appears after reset release.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory request path.
package mem_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 16;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef struct packed {
        logic                  wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request FIFO; head is read straight from the storage registers.
module mem_req_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  mem_req_t         push_data,
    input  logic             pop,
    output mem_req_t         head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    mem_req_t         storage_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = storage_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mem_req_sched.sv
// Host request scheduler in front of the single-port memory: queues requests,
// issues one per cycle in order, and returns read data over valid/ready.
module mem_req_sched
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = mem_ctrl_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = mem_ctrl_pkg::ADDR_WIDTH,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [ADDR_WIDTH-1:0]      req_addr,
    input  logic [DATA_WIDTH-1:0]      req_wdata,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [DATA_WIDTH-1:0]      resp_rdata,
    output logic                       mem_rd_wr_valid,
    output logic                       mem_rd_wr_mem,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wr_data,
    input  logic [DATA_WIDTH-1:0]      mem_rd_data,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    mem_req_t                push_data;
    mem_req_t                head;
    logic                    full;
    logic                    empty;
    logic                    issue;
    logic                    rd_ok;
    logic                    rd_inflight_q, rd_inflight_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;

    assign req_ready = !full;
    assign push_data = '{wr: req_wr, addr: req_addr, wdata: req_wdata};

    mem_req_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid && req_ready),
        .push_data (push_data),
        .pop       (issue),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    always_comb begin
        rd_ok           = !rd_inflight_q && (!resp_valid_q || resp_ready);
        issue           = !empty && ((head.wr == OP_WR) || rd_ok);
        mem_rd_wr_valid = issue;
        mem_rd_wr_mem   = head.wr;
        mem_addr        = head.addr;
        mem_wr_data     = head.wdata;

        rd_inflight_d = issue && (head.wr == OP_RD);
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        // A capture takes priority over a same-edge host handshake.
        if (rd_inflight_q) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = mem_rd_data;
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_inflight_q <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_rdata_q  <= '0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
            resp_valid_q  <= resp_valid_d;
            resp_rdata_q  <= resp_rdata_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_req_sched.sv
// Scoreboard bench for mem_req_sched with a registered-read memory model.
module tb_mem_req_sched;
    import mem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        mem_rd_wr_valid;
    logic        mem_rd_wr_mem;
    logic [15:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data = '0;
    logic [3:0]  fifo_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    mem_req_t    exp_issue[$];
    logic [31:0] exp_resp[$];
    logic [31:0] mem_model [logic [15:0]];

    mem_req_sched #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(16),
        .DEPTH(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_wr          (req_wr),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .mem_rd_wr_valid (mem_rd_wr_valid),
        .mem_rd_wr_mem   (mem_rd_wr_mem),
        .mem_addr        (mem_addr),
        .mem_wr_data     (mem_wr_data),
        .mem_rd_data     (mem_rd_data),
        .fifo_count      (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory samples on the issue edge; read data is registered.
    always @(posedge clk) begin
        if (mem_rd_wr_valid) begin
            if (mem_rd_wr_mem) begin
                mem_model[mem_addr] = mem_wr_data;
            end else begin
                mem_rd_data <= mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        mem_req_t e;
        if (!rst && mem_rd_wr_valid) begin
            if (exp_issue.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL issue_unexpected: got wr=%0b addr=0x%0h expected no issue", mem_rd_wr_mem, mem_addr);
            end else begin
                e = exp_issue.pop_front();
                chk("issue", {15'd0, mem_rd_wr_mem, mem_addr, mem_wr_data}, {15'd0, e.wr, e.addr, e.wdata});
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] r;
        if (!rst && resp_valid && resp_ready) begin
            if (exp_resp.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: got 0x%0h expected no response", resp_rdata);
            end else begin
                r = exp_resp.pop_front();
                chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, r});
            end
        end
    end

    task automatic push_req(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rd);
        int unsigned waited = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        while (1) begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 50) begin
                chk("push_timeout", 64'd0, 64'd1);
                req_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        exp_issue.push_back('{wr: wr, addr: addr, wdata: wr ? wdata : 32'h0 ^ wdata});
        if (!wr) exp_resp.push_back(exp_rd);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int unsigned t0;
        int unsigned lat;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values held through idle.
        repeat (10) begin
            @(negedge clk);
            chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
            chk("idle_resp_valid", {63'd0, resp_valid}, 64'd0);
            chk("idle_fifo_count", {60'd0, fifo_count}, 64'd0);
            chk("idle_mem_valid", {63'd0, mem_rd_wr_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Write then read back, measuring read latency.
        push_req(1'b1, 16'h0010, 32'hDEADBEEF, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        push_req(1'b0, 16'h0010, 32'h0, 32'hDEADBEEF);
        t0  = cyc;
        lat = 99;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = cyc - t0;
                break;
            end
        end
        chk("read_latency", 64'(lat), 64'd2);
        repeat (3) @(posedge clk);
        #1;

        // Held response blocks a queued read and the writes behind it.
        push_req(1'b1, 16'h0020, 32'h20202020, 32'h0);
        push_req(1'b1, 16'h0021, 32'h21212121, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        push_req(1'b0, 16'h0020, 32'h0, 32'h20202020);
        push_req(1'b0, 16'h0021, 32'h0, 32'h21212121);
        for (int i = 0; i < 7; i++) begin
            push_req(1'b1, 16'h0040 + 16'(i), 32'h40400000 + 32'(i), 32'h0);
        end
        chk("full_count", {60'd0, fifo_count}, 64'd8);
        chk("full_req_ready", {63'd0, req_ready}, 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("blocked_mem_valid", {63'd0, mem_rd_wr_valid}, 64'd0);
            chk("held_resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("held_resp_rdata", {32'd0, resp_rdata}, {32'd0, 32'h20202020});
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("drain_mem_valid", {63'd0, mem_rd_wr_valid}, 64'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("drain_count", {60'd0, fifo_count}, 64'd0);
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back writes across the pointer wrap keep occupancy at one.
        for (int i = 0; i < 20; i++) begin
            push_req(1'b1, 16'h0100 + 16'(i), 32'hA5000000 + 32'(i), 32'h0);
            chk("wrap_count", {60'd0, fifo_count}, 64'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        push_req(1'b0, 16'h0113, 32'h0, 32'hA5000013);
        push_req(1'b0, 16'h0107, 32'h0, 32'hA5000007);
        push_req(1'b0, 16'h0041, 32'h0, 32'h40400001);
        repeat (8) @(posedge clk);
        #1;

        // Reset with one read in flight and another queued.
        push_req(1'b1, 16'h0030, 32'h30303030, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        push_req(1'b0, 16'h0030, 32'h0, 32'h30303030);
        push_req(1'b0, 16'h0021, 32'h0, 32'h21212121);
        rst = 1'b1;
        exp_issue.delete();
        exp_resp.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_fifo_count", {60'd0, fifo_count}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
            chk("post_rst_mem_valid", {63'd0, mem_rd_wr_valid}, 64'd0);
        end

        for (int i = 0; i < 50; i++) begin
            if (exp_issue.size() == 0 && exp_resp.size() == 0) break;
            @(posedge clk);
        end
        chk("issue_queue_empty", 64'(exp_issue.size()), 64'd0);
        chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
